// File: rtl/multicycle_control.sv
// Multicycle CPU control sequencer: owns PC and IR, steps fetch/decode/execute
// and drives memory, register-file and ALU control lines for each instruction.
module multicycle_control #(
    parameter int                     PC_WIDTH   = 16,
    parameter int                     DATA_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic [DATA_WIDTH-1:0] reg_b_val,
    input  logic [4:0]            flags,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [PC_WIDTH-1:0]   mem_addr,
    output logic                  mem_we,
    output logic [3:0]            reg_read_a,
    output logic [3:0]            reg_read_b,
    output logic [3:0]            reg_write,
    output logic                  reg_we,
    output logic                  wb_sel,
    output logic                  imm_sel,
    output logic [7:0]            alu_opcode,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_LD_ADDR = 3'd3,
        S_LD_WB   = 3'd4,
        S_BRANCH  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_ITYPE, C_LOAD, C_STOR, C_JCOND, C_BCOND, C_NOP
    } iclass_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_t  state;
    iclass_t ir_class;
    logic    cond_ok;
    logic [PC_WIDTH-1:0] disp_ext;

    function automatic iclass_t classify(input logic [15:0] w);
        iclass_t c;
        c = C_ITYPE;
        case (w[15:12])
            4'b0000: c = C_RTYPE;
            4'b1100: c = C_BCOND;
            4'b0100: begin
                case (w[7:4])
                    4'b0000: c = C_LOAD;
                    4'b0100: c = C_STOR;
                    4'b1100: c = C_JCOND;
                    default: c = C_NOP;
                endcase
            end
            default: c = C_ITYPE;
        endcase
        return c;
    endfunction

    // flags = {C, L, F, Z, N}
    function automatic logic cond_true(input logic [3:0] cond, input logic [4:0] f);
        logic c_f, l_f, f_f, z_f, n_f, r;
        {c_f, l_f, f_f, z_f, n_f} = f;
        case (cond)
            4'h0: r = z_f;
            4'h1: r = !z_f;
            4'h2: r = c_f;
            4'h3: r = !c_f;
            4'h4: r = l_f;
            4'h5: r = !l_f;
            4'h6: r = f_f;
            4'h7: r = !f_f;
            4'h8: r = n_f;
            4'h9: r = !n_f;
            4'hA: r = !l_f && !z_f;
            4'hB: r = l_f || z_f;
            4'hC: r = !n_f && !z_f;
            4'hD: r = n_f || z_f;
            4'hE: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign ir_class = classify(ir[15:0]);
    assign cond_ok  = cond_true(ir[11:8], flags);
    assign disp_ext = {{(PC_WIDTH-8){ir[7]}}, ir[7:0]};

    // Stall freezes everything; reset still wins because it is checked first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else if (!stall) begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir <= instr_in;
                    case (classify(instr_in[15:0]))
                        C_LOAD:           state <= S_LD_ADDR;
                        C_BCOND, C_JCOND: state <= S_BRANCH;
                        default:          state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    pc    <= pc + PC_ONE;
                    state <= S_FETCH;
                end
                S_LD_ADDR: state <= S_LD_WB;
                S_LD_WB: begin
                    pc    <= pc + PC_ONE;
                    state <= S_FETCH;
                end
                S_BRANCH: begin
                    if (!cond_ok)
                        pc <= pc + PC_ONE;
                    else if (ir_class == C_JCOND)
                        pc <= reg_b_val[PC_WIDTH-1:0];
                    else
                        pc <= pc + disp_ext;
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_addr = pc;
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        case (state)
            S_EXEC: begin
                if (ir_class == C_STOR) begin
                    mem_addr = reg_b_val[PC_WIDTH-1:0];
                    mem_we   = !stall;
                end else if (ir_class == C_RTYPE || ir_class == C_ITYPE) begin
                    reg_we = !stall;
                end
            end
            S_LD_ADDR: mem_addr = reg_b_val[PC_WIDTH-1:0];
            S_LD_WB: begin
                reg_we = !stall;
                wb_sel = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm_sel    = (ir_class == C_ITYPE);
    assign reg_read_a = ir[11:8];
    assign reg_read_b = ir[3:0];
    assign reg_write  = ir[11:8];
    assign alu_opcode = {ir[15:12], ir[7:4]};
    assign state_dbg  = state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multicycle CPU control FSM. Generalises the fetch/decode/execute sequencer with configurable PC width and reset vector.
- Adds load/store memory states, conditional branch (PC-relative), conditional jump (register), and a stall input.
- Sits between the Memory, Register_File and ALU blocks. It drives their address, select and write-enable lines and owns the PC and IR.

Parameters:
- PC_WIDTH, 16, width of PC and of mem_addr.
- DATA_WIDTH, 16, instruction/data word width. Must be ≥16.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  when high, freeze state/PC/IR; all write enables forced 0.
- instr_in  in  DATA_WIDTH  memory read data, valid the cycle after mem_addr is driven (1-cycle synchronous RAM).
- reg_b_val  in  DATA_WIDTH  register file read port B data (address source for LOAD/STOR/Jcond).
- flags  in  5  ALU flags registered by datapath, {C,L,F,Z,N} = flags[4:0].
- pc  out  PC_WIDTH  current program counter.
- ir  out  DATA_WIDTH  latched instruction.
- mem_addr  out  PC_WIDTH  memory port A address.
- mem_we  out  1  memory port A write enable.
- reg_read_a  out  4  = ir[11:8] (rdest).
- reg_read_b  out  4  = ir[3:0] (rsrc).
- reg_write  out  4  = ir[11:8].
- reg_we  out  1  register file write enable.
- wb_sel  out  1  0 = ALU result, 1 = memory data.
- imm_sel  out  1  1 = ALU B operand is sign-extended ir[7:0].
- alu_opcode  out  8  = {ir[15:12], ir[7:4]}.
- state_dbg  out  3  current state encoding.

Behaviour:
- Decode fields: op = [15:12], rdest/cond = [11:8], opext = [7:4], rsrc = [3:0], imm8/disp = [7:0].
- Instruction classes:
  - op 0000 = RTYPE.
  - op 0100: opext 0000 = LOAD, 0100 = STOR, 1100 = Jcond.
  - op 1100 = Bcond.
  - all other ops = ITYPE (imm_sel = 1).
  - op 0100 with any other opext = NOP.
- States (encoding): FETCH=0, DECODE=1, EXEC=2, LD_ADDR=3, LD_WB=4, BRANCH=5.
  - FETCH: mem_addr = pc. Next → DECODE.
  - DECODE: ir <= instr_in. Next is chosen from instr_in: RTYPE/ITYPE/STOR/NOP → EXEC; LOAD → LD_ADDR; Bcond/Jcond → BRANCH.
  - EXEC:
    - RTYPE/ITYPE: reg_we = 1, wb_sel = 0.
    - STOR: mem_addr = reg_b_val[PC_WIDTH-1:0], mem_we = 1 (data path from reg A handled by datapath).
    - NOP: no enables.
    - Then pc <= pc+1 and → FETCH.
  - LD_ADDR: mem_addr = reg_b_val. Next → LD_WB.
  - LD_WB: reg_we = 1, wb_sel = 1, pc <= pc+1. Next → FETCH.
  - BRANCH:
    - Bcond taken: pc <= pc + sext(disp).
    - Jcond taken: pc <= reg_b_val.
    - Not taken: pc <= pc+1.
    - Next → FETCH.
- Outside the listed cycles, mem_addr = pc.
- Cycle counts: RTYPE/ITYPE/STOR/NOP 3, LOAD 4, branch/jump 3.
- Condition codes (cond field):
  - 0 EQ Z
  - 1 NE !Z
  - 2 CS C
  - 3 CC !C
  - 4 HI L
  - 5 LS !L
  - 6 FS F
  - 7 FC !F
  - 8 GT N
  - 9 LE !N
  - A LO !L&!Z
  - B HS L|Z
  - C LT !N&!Z
  - D GE N|Z
  - E UC 1
  - F never
- Arithmetic: all PC math is modulo 2^PC_WIDTH; wrap is silent. disp is sign-extended from 8 bits to PC_WIDTH.
- Outputs are combinational from state and ir. reg_we/mem_we are asserted for exactly one cycle per instruction.
- Reset:
  - pc = RESET_PC, state = FETCH, ir = 0.
  - reg_we = mem_we = wb_sel = imm_sel = 0.
  - Reset mid-instruction aborts it with no write.
  - Reset overrides stall.
- Stall:
  - Holds state, pc and ir.
  - reg_we and mem_we are forced 0 during stall; the pending write fires on the first unstalled cycle in that state.
  - Stall in DECODE does not re-latch ir until released; instr_in must remain valid (mem_addr held).

Test Plan:
- Reset → pc = 0, state_dbg = 0, all enables 0. Run NOPs (0x4010) → pc advances 1 every 3 cycles.
- RTYPE 0x0152 at pc=0 → DECODE ir = 0x0152; EXEC reg_we = 1, reg_write = 1, reg_read_b = 2, alu_opcode = 0x05; pc = 1 on return to FETCH.
- LOAD 0x4304 with reg_b_val = 0x0020 → LD_ADDR mem_addr = 0x0020; LD_WB reg_we = 1, wb_sel = 1; 4 cycles total. STOR 0x4443 → single mem_we pulse at 0x0020.
- Bcond BEQ disp = 0xFE at pc = 5: Z = 1 → pc = 3; Z = 0 → pc = 6. BUC disp = 0x7F at pc = 0xFFF0 → pc = 0x006F (wrap).
- Jcond JUC 0x4EC7 with reg_b_val = 0x1234 → pc = 0x1234; cond F → pc+1.
- Stall held 4 cycles in EXEC → no reg_we, pc frozen, one reg_we after release. Reset asserted during LD_ADDR → pc = RESET_PC, no reg_we.
